forward_operand_unit: RTL and testbench

- Parametrised, registered operand-forwarding stage at the EX input of the pipelined processor.
- Resolves NUM_SRC source operands per instruction from four places, in priority order: EX/MEM result, MEM/WB result, an internal write-back history buffer, then register-file read data.
- Detects load-use hazards and runs a stall sequencer that requests upstream freeze for LOAD_LAT cycles.

---
 rtl/forward_operand_unit.sv | 163 ++++++++++++++++
 tb/tb_forward_operand_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/forward_operand_unit.sv
// Registered EX-input operand forwarding with a write-back history buffer and
// a load-use stall sequencer that freezes upstream for LOAD_LAT cycles.
module forward_operand_unit #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned HIST_DEPTH = 1,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic                      hold_in,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC*DATA_W-1:0] src_rf_data,
    input  logic                      exmem_regwrite,
    input  logic                      exmem_is_load,
    input  logic [ADDR_W-1:0]         exmem_rd,
    input  logic [DATA_W-1:0]         exmem_data,
    input  logic                      memwb_regwrite,
    input  logic [ADDR_W-1:0]         memwb_rd,
    input  logic [DATA_W-1:0]         memwb_data,
    output logic [NUM_SRC*DATA_W-1:0] operand_out,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic                      out_valid,
    output logic                      stall_req
);

    typedef enum logic {StRun, StStall} stateT;

    localparam logic [1:0] SelRf    = 2'b00;
    localparam logic [1:0] SelMemWb = 2'b01;
    localparam logic [1:0] SelExMem = 2'b10;
    localparam logic [1:0] SelHist  = 2'b11;

    stateT       stateQ, stateD;
    logic [2:0]  countQ, countD;
    logic        advance, bubble, hazard;

    logic              histValidQ [HIST_DEPTH];
    logic [ADDR_W-1:0] histRdQ    [HIST_DEPTH];
    logic [DATA_W-1:0] histDataQ  [HIST_DEPTH];
    logic              histNewValid;

    logic [ADDR_W-1:0] chAddr    [NUM_SRC];
    logic              chZero    [NUM_SRC];
    logic              chWbMatch [NUM_SRC];
    logic              chHistHit [NUM_SRC];
    logic [DATA_W-1:0] chHistVal [NUM_SRC];
    logic [NUM_SRC-1:0]        exMatch;
    logic [NUM_SRC*DATA_W-1:0] operandD;
    logic [NUM_SRC*2-1:0]      selD;

    assign histNewValid = memwb_regwrite && !((ZERO_REG != 0) && (memwb_rd == '0));

    // Per-channel match and source selection.
    always_comb begin
        exMatch  = '0;
        operandD = '0;
        selD     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            chAddr[i]    = src_addr[i*ADDR_W +: ADDR_W];
            chZero[i]    = (ZERO_REG != 0) && (chAddr[i] == '0);
            exMatch[i]   = exmem_regwrite && (exmem_rd == chAddr[i]) && !chZero[i];
            chWbMatch[i] = memwb_regwrite && (memwb_rd == chAddr[i]) && !chZero[i];
            chHistHit[i] = 1'b0;
            chHistVal[i] = '0;
            // Walk oldest to newest so the newest matching entry wins.
            for (int j = int'(HIST_DEPTH) - 1; j >= 0; j--) begin
                if (histValidQ[j] && (histRdQ[j] == chAddr[i])) begin
                    chHistHit[i] = 1'b1;
                    chHistVal[i] = histDataQ[j];
                end
            end
            if (chZero[i]) begin
                operandD[i*DATA_W +: DATA_W] = '0;
                selD[i*2 +: 2]               = SelRf;
            end else if (exMatch[i] && !exmem_is_load) begin
                operandD[i*DATA_W +: DATA_W] = exmem_data;
                selD[i*2 +: 2]               = SelExMem;
            end else if (chWbMatch[i]) begin
                operandD[i*DATA_W +: DATA_W] = memwb_data;
                selD[i*2 +: 2]               = SelMemWb;
            end else if (chHistHit[i]) begin
                operandD[i*DATA_W +: DATA_W] = chHistVal[i];
                selD[i*2 +: 2]               = SelHist;
            end else begin
                operandD[i*DATA_W +: DATA_W] = src_rf_data[i*DATA_W +: DATA_W];
                selD[i*2 +: 2]               = SelRf;
            end
        end
        hazard = in_valid && exmem_is_load && (|exMatch);
    end

    // Stall sequencer: hold_in freezes everything and wins over hazards.
    always_comb begin
        stateD    = stateQ;
        countD    = countQ;
        stall_req = 1'b0;
        advance   = 1'b0;
        bubble    = 1'b0;
        if (!hold_in) begin
            case (stateQ)
                StRun: begin
                    if (hazard) begin
                        stall_req = 1'b1;
                        bubble    = 1'b1;
                        countD    = 3'(LOAD_LAT - 1);
                        if (LOAD_LAT > 1) stateD = StStall;
                    end else begin
                        advance = 1'b1;
                    end
                end
                StStall: begin
                    bubble = 1'b1;
                    if (countQ == 3'd0) begin
                        stateD = StRun;
                    end else begin
                        stall_req = 1'b1;
                        countD    = countQ - 3'd1;
                    end
                end
                default: stateD = StRun;
            endcase
        end
        if (reset) stall_req = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stateQ      <= StRun;
            countQ      <= 3'd0;
            operand_out <= '0;
            fwd_sel     <= '0;
            out_valid   <= 1'b0;
            for (int j = 0; j < HIST_DEPTH; j++) begin
                histValidQ[j] <= 1'b0;
                histRdQ[j]    <= '0;
                histDataQ[j]  <= '0;
            end
        end else if (!hold_in) begin
            stateQ <= stateD;
            countQ <= countD;
            for (int j = int'(HIST_DEPTH) - 1; j >= 1; j--) begin
                histValidQ[j] <= histValidQ[j-1];
                histRdQ[j]    <= histRdQ[j-1];
                histDataQ[j]  <= histDataQ[j-1];
            end
            histValidQ[0] <= histNewValid;
            histRdQ[0]    <= memwb_rd;
            histDataQ[0]  <= memwb_data;
            if (advance) begin
                operand_out <= operandD;
                fwd_sel     <= selD;
                out_valid   <= in_valid;
            end else if (bubble) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_forward_operand_unit.sv
// Bench for forward_operand_unit: two instances (LOAD_LAT=1/HIST_DEPTH=1 and
// LOAD_LAT=3/HIST_DEPTH=2) share stimulus and are checked against a reference model.
module tb_forward_operand_unit;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, in_valid, hold_in;
    logic [7:0]  src_addr;
    logic [31:0] src_rf_data;
    logic        exmem_regwrite, exmem_is_load;
    logic [3:0]  exmem_rd;
    logic [15:0] exmem_data;
    logic        memwb_regwrite;
    logic [3:0]  memwb_rd;
    logic [15:0] memwb_data;

    logic [31:0] opA, opB;
    logic [3:0]  selA, selB;
    logic        vA, vB, stA, stB;

    forward_operand_unit #(.HIST_DEPTH(1), .LOAD_LAT(1)) dutA (
        .clock(clock), .reset(reset), .in_valid(in_valid), .hold_in(hold_in),
        .src_addr(src_addr), .src_rf_data(src_rf_data),
        .exmem_regwrite(exmem_regwrite), .exmem_is_load(exmem_is_load),
        .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .operand_out(opA), .fwd_sel(selA), .out_valid(vA), .stall_req(stA)
    );

    forward_operand_unit #(.HIST_DEPTH(2), .LOAD_LAT(3)) dutB (
        .clock(clock), .reset(reset), .in_valid(in_valid), .hold_in(hold_in),
        .src_addr(src_addr), .src_rf_data(src_rf_data),
        .exmem_regwrite(exmem_regwrite), .exmem_is_load(exmem_is_load),
        .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .operand_out(opB), .fwd_sel(selB), .out_valid(vB), .stall_req(stB)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state, index 0 = dutA, 1 = dutB.
    int          lat [2] = '{1, 3};
    int          hd  [2] = '{1, 2};
    logic [31:0] expOp  [2] = '{32'h0, 32'h0};
    logic [3:0]  expSel [2] = '{4'h0, 4'h0};
    logic        expV   [2] = '{1'b0, 1'b0};
    int          pend   [2] = '{0, 0};   // remaining cycles of the stall window
    logic        mHv    [2][4];
    logic [3:0]  mHrd   [2][4];
    logic [15:0] mHd    [2][4];

    function automatic logic [17:0] resolveCh(int k, int ch);
        logic [3:0] a;
        a = src_addr[ch*4 +: 4];
        if (a == 4'd0) return 18'h0;
        if (exmem_regwrite && exmem_rd == a && !exmem_is_load) return {2'b10, exmem_data};
        if (memwb_regwrite && memwb_rd == a) return {2'b01, memwb_data};
        for (int j = 0; j < hd[k]; j++)
            if (mHv[k][j] && mHrd[k][j] == a) return {2'b11, mHd[k][j]};
        return {2'b00, src_rf_data[ch*16 +: 16]};
    endfunction

    function automatic logic hazardM();
        logic hit;
        hit = 1'b0;
        for (int ch = 0; ch < 2; ch++)
            if (src_addr[ch*4 +: 4] == exmem_rd && src_addr[ch*4 +: 4] != 4'd0) hit = 1'b1;
        return in_valid && exmem_regwrite && exmem_is_load && hit;
    endfunction

    function automatic logic expStall(int k);
        if (reset || hold_in) return 1'b0;
        if (pend[k] > 0) return pend[k] > 1;
        return hazardM();
    endfunction

    task automatic modelEdge(int k);
        logic [17:0] r0, r1;
        if (reset) begin
            expOp[k] = '0; expSel[k] = '0; expV[k] = 1'b0; pend[k] = 0;
            for (int j = 0; j < 4; j++) mHv[k][j] = 1'b0;
        end else if (!hold_in) begin
            if (pend[k] > 0) begin
                expV[k] = 1'b0;
                pend[k]--;
            end else if (hazardM()) begin
                expV[k] = 1'b0;
                pend[k] = (lat[k] > 1) ? lat[k] : 0;
            end else begin
                r0 = resolveCh(k, 0);
                r1 = resolveCh(k, 1);
                expOp[k]  = {r1[15:0], r0[15:0]};
                expSel[k] = {r1[17:16], r0[17:16]};
                expV[k]   = in_valid;
            end
            for (int j = 3; j >= 1; j--) begin
                mHv[k][j] = mHv[k][j-1]; mHrd[k][j] = mHrd[k][j-1]; mHd[k][j] = mHd[k][j-1];
            end
            mHv[k][0]  = memwb_regwrite && memwb_rd != 4'd0;
            mHrd[k][0] = memwb_rd;
            mHd[k][0]  = memwb_data;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        modelEdge(0);
        modelEdge(1);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; hold_in = 1'b0; in_valid = 1'b0;
        src_addr = '0; src_rf_data = '0;
        exmem_regwrite = 1'b0; exmem_is_load = 1'b0; exmem_rd = '0; exmem_data = '0;
        memwb_regwrite = 1'b0; memwb_rd = '0; memwb_data = '0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1; in_valid = 1'b1;
        #1;
        checks++;
        if ({stA, stB} !== 2'b00) begin
            failures++; $display("FAIL reset_stall got=%b want=00", {stA, stB});
        end
        tick();
        checks++;
        if ({opA, selA, vA, opB, selB, vB} !== 74'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h/%h/%b %h/%h/%b want=all zero",
                     opA, selA, vA, opB, selB, vB);
        end
        reset = 1'b0;
    endtask

    task automatic test_priority();
        idle();
        in_valid = 1'b1; src_addr = {4'd1, 4'd3}; src_rf_data = {16'h0, 16'h3333};
        exmem_regwrite = 1'b1; exmem_rd = 4'd3; exmem_data = 16'h1111;
        memwb_regwrite = 1'b1; memwb_rd = 4'd3; memwb_data = 16'h2222;
        #1;
        checks++;
        if ({stA, stB} !== 2'b00) begin
            failures++; $display("FAIL prio_stall got=%b want=00", {stA, stB});
        end
        tick();
        checks++;
        if ({opA[15:0], selA[1:0], vA} !== {16'h1111, 2'b10, 1'b1} ||
            {opB[15:0], selB[1:0], vB} !== {16'h1111, 2'b10, 1'b1}) begin
            failures++;
            $display("FAIL prio_exmem got=%h/%b %h/%b want=1111/10", opA[15:0], selA[1:0],
                     opB[15:0], selB[1:0]);
        end
    endtask

    task automatic test_wb_zero();
        idle();
        in_valid = 1'b1; src_addr = {4'd5, 4'd0}; src_rf_data = {16'h7777, 16'h5555};
        exmem_regwrite = 1'b1; exmem_rd = 4'd0; exmem_data = 16'hFFFF;
        memwb_regwrite = 1'b1; memwb_rd = 4'd5; memwb_data = 16'hBEEF;
        tick();
        checks++;
        if ({opA, selA} !== {32'hBEEF_0000, 4'b0100} || {opB, selB} !== {32'hBEEF_0000, 4'b0100})
        begin
            failures++;
            $display("FAIL wb_zero got=%h/%b %h/%b want=beef0000/0100", opA, selA, opB, selB);
        end
    endtask

    task automatic test_history();
        idle();
        in_valid = 1'b1; src_addr = {4'd1, 4'd1};
        memwb_regwrite = 1'b1; memwb_rd = 4'd7; memwb_data = 16'h00A5;
        tick();
        idle();
        in_valid = 1'b1; src_addr = {4'd1, 4'd7};
        tick();
        checks++;
        if ({opA[15:0], selA[1:0]} !== {16'h00A5, 2'b11} ||
            {opB[15:0], selB[1:0]} !== {16'h00A5, 2'b11}) begin
            failures++;
            $display("FAIL hist_hit got=%h/%b %h/%b want=00a5/11", opA[15:0], selA[1:0],
                     opB[15:0], selB[1:0]);
        end
        for (int n = 0; n < 2; n++) begin
            idle();
            memwb_regwrite = 1'b1; memwb_rd = 4'(9 + n); memwb_data = 16'h0F0F;
            tick();
        end
        idle();
        in_valid = 1'b1; src_addr = {4'd1, 4'd7}; src_rf_data = {16'h0, 16'h1234};
        tick();
        checks++;
        if ({opA[15:0], selA[1:0]} !== {16'h1234, 2'b00} ||
            {opB[15:0], selB[1:0]} !== {16'h1234, 2'b00}) begin
            failures++;
            $display("FAIL hist_expire got=%h/%b %h/%b want=1234/00", opA[15:0], selA[1:0],
                     opB[15:0], selB[1:0]);
        end
    endtask

    task automatic test_load_use();
        idle();
        in_valid = 1'b1; src_addr = {4'd2, 4'd0};
        exmem_regwrite = 1'b1; exmem_is_load = 1'b1; exmem_rd = 4'd2; exmem_data = 16'hDEAD;
        #1;
        checks++;
        if ({stA, stB} !== 2'b11) begin
            failures++; $display("FAIL lu_stall got=%b want=11", {stA, stB});
        end
        tick();
        checks++;
        if ({vA, vB} !== 2'b00) begin
            failures++; $display("FAIL lu_bubble got=%b want=00", {vA, vB});
        end
        idle();
        in_valid = 1'b1; src_addr = {4'd2, 4'd0};
        memwb_regwrite = 1'b1; memwb_rd = 4'd2; memwb_data = 16'h4242;
        #1;
        checks++;
        if ({stA, stB} !== 2'b01) begin
            failures++; $display("FAIL lu_release got=%b want=01", {stA, stB});
        end
        tick();
        checks++;
        if ({opA[31:16], selA[3:2], vA, vB} !== {16'h4242, 2'b01, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL lu_forward got=%h/%b/%b/%b want=4242/01/1/0", opA[31:16], selA[3:2],
                     vA, vB);
        end
        idle();
        for (int n = 0; n < 3; n++) tick();
        checks++;
        if ({opB, selB, vB} !== {expOp[1], expSel[1], expV[1]}) begin
            failures++;
            $display("FAIL lu_drain got=%h/%h/%b want=%h/%h/%b", opB, selB, vB,
                     expOp[1], expSel[1], expV[1]);
        end
    endtask

    task automatic test_lat3_hold();
        int cnt;
        cnt = 0;
        idle();
        in_valid = 1'b1; src_addr = {4'd0, 4'd4};
        exmem_regwrite = 1'b1; exmem_is_load = 1'b1; exmem_rd = 4'd4;
        #1;
        if (stB) cnt++;
        tick();
        idle();
        hold_in = 1'b1;
        for (int n = 0; n < 2; n++) begin
            #1;
            checks++;
            if ({stA, stB} !== 2'b00) begin
                failures++; $display("FAIL hold_stall got=%b want=00", {stA, stB});
            end
            tick();
            checks++;
            if ({opB, selB, vB} !== {expOp[1], expSel[1], 1'b0}) begin
                failures++;
                $display("FAIL hold_frozen got=%h/%h/%b want=%h/%h/0", opB, selB, vB,
                         expOp[1], expSel[1]);
            end
        end
        idle();
        for (int n = 0; n < 10; n++) begin
            #1;
            if (!stB) break;
            cnt++;
            tick();
        end
        checks++;
        if (cnt != 3) begin
            failures++; $display("FAIL lat3_count got=%0d want=3", cnt);
        end
        tick();
        // Reset in the middle of a fresh stall.
        in_valid = 1'b1; src_addr = {4'd0, 4'd4};
        exmem_regwrite = 1'b1; exmem_is_load = 1'b1; exmem_rd = 4'd4;
        tick();
        idle();
        reset = 1'b1;
        #1;
        checks++;
        if (stB !== 1'b0) begin
            failures++; $display("FAIL rst_mid_stall got=%b want=0", stB);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({stB, vB} !== 2'b00) begin
            failures++; $display("FAIL rst_after got=%b want=00", {stB, vB});
        end
        tick();
        checks++;
        if ({opB, selB, vB, stB} !== 38'h0) begin
            failures++; $display("FAIL rst_clean got=%h/%h/%b/%b want=0", opB, selB, vB, stB);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset          = ($urandom % 64) == 0;
            hold_in        = ($urandom % 8) == 0;
            in_valid       = ($urandom % 4) != 0;
            src_addr       = {2'b00, 2'($urandom), 2'b00, 2'($urandom)};
            src_rf_data    = $urandom;
            exmem_regwrite = $urandom % 2 == 1;
            exmem_is_load  = ($urandom % 4) == 0;
            exmem_rd       = {2'b00, 2'($urandom)};
            exmem_data     = 16'($urandom);
            memwb_regwrite = $urandom % 2 == 1;
            memwb_rd       = {2'b00, 2'($urandom)};
            memwb_data     = 16'($urandom);
            #1;
            checks++;
            if ({stA, stB} !== {expStall(0), expStall(1)}) begin
                failures++;
                $display("FAIL rnd_stall cyc=%0d got=%b want=%b", n, {stA, stB},
                         {expStall(0), expStall(1)});
            end
            tick();
            checks++;
            if ({opA, selA, vA, opB, selB, vB} !==
                {expOp[0], expSel[0], expV[0], expOp[1], expSel[1], expV[1]}) begin
                failures++;
                $display("FAIL rnd_out cyc=%0d got=%h/%h/%b %h/%h/%b want=%h/%h/%b %h/%h/%b",
                         n, opA, selA, vA, opB, selB, vB, expOp[0], expSel[0], expV[0],
                         expOp[1], expSel[1], expV[1]);
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_priority();
        test_wb_zero();
        test_history();
        test_load_use();
        test_lat3_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
